// File: rtl/adder_arbiter_pkg.sv
// Shared definitions for the two-requester add/subtract arbiter.
package adder_arbiter_pkg;

    localparam int unsigned DATA_W = 64;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC1 = 2'd1,
        EXEC2 = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Round-robin pick: a lone requester wins, a tie goes to the one not granted last.
    function automatic logic pick_grant(input logic v0, input logic v1, input logic last);
        logic g;
        if (v0 && v1) begin
            g = ~last;
        end else if (v1) begin
            g = 1'b1;
        end else begin
            g = 1'b0;
        end
        return g;
    endfunction

endpackage

// File: rtl/adder_arbiter_add_64_bit.sv
// Plain 64-bit adder with carry-in and carry-out; the only arithmetic in the arbiter.
module add_64_bit
    import adder_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              cin,
    output logic [DATA_W-1:0] sum,
    output logic              cout
);

    logic [DATA_W:0] full_s;

    // Widen by one bit so the carry out of bit 63 lands in the top bit.
    always_comb begin
        full_s = {1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin};
    end

    assign sum  = full_s[DATA_W-1:0];
    assign cout = full_s[DATA_W];

endmodule

// File: rtl/adder_arbiter.sv
// Two requesters share one adder; one operation in flight, round-robin on ties.
// Subtract runs as a + ~b in EXEC1 followed by +1 in EXEC2.
module adder_arbiter
    import adder_arbiter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [63:0] req0_a,
    input  logic [63:0] req0_b,
    input  logic        req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [63:0] req1_a,
    input  logic [63:0] req1_b,
    input  logic        req1_op,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_id,
    output logic [63:0] rsp_sum,
    output logic        rsp_cout,
    output logic        busy
);

    state_t            state_r;
    logic              last_grant_r;
    logic [DATA_W-1:0] opa_r;
    logic [DATA_W-1:0] opb_r;
    logic              op_r;
    logic              id_r;
    logic [DATA_W-1:0] tmp_sum_r;
    logic              tmp_cout_r;
    logic              rsp_valid_r;
    logic              rsp_id_r;
    logic [DATA_W-1:0] rsp_sum_r;
    logic              rsp_cout_r;
    logic              busy_r;

    logic              grant_s;
    logic              accept_s;
    logic [DATA_W-1:0] add_a_s;
    logic [DATA_W-1:0] add_b_s;
    logic              add_cin_s;
    logic [DATA_W-1:0] add_sum_s;
    logic              add_cout_s;

    // Arbitration and handshake; ready is held low while reset is asserted.
    always_comb begin
        grant_s  = pick_grant(req0_valid, req1_valid, last_grant_r);
        accept_s = 1'b0;
        if (rst_n && (state_r == IDLE) && (req0_valid || req1_valid)) begin
            accept_s = 1'b1;
        end else begin
            accept_s = 1'b0;
        end
    end

    assign req0_ready = accept_s & ~grant_s;
    assign req1_ready = accept_s &  grant_s;

    // Operand steering for the shared adder: first pass or the +1 pass of a subtract.
    always_comb begin
        add_a_s   = opa_r;
        add_b_s   = opb_r;
        add_cin_s = 1'b0;
        case (state_r)
            EXEC1: begin
                add_a_s   = opa_r;
                add_b_s   = (op_r == OP_SUB) ? ~opb_r : opb_r;
                add_cin_s = 1'b0;
            end
            EXEC2: begin
                add_a_s   = tmp_sum_r;
                add_b_s   = {DATA_W{1'b0}};
                add_cin_s = 1'b1;
            end
            default: begin
                add_a_s   = opa_r;
                add_b_s   = opb_r;
                add_cin_s = 1'b0;
            end
        endcase
    end

    add_64_bit u_add (
        .a    (add_a_s),
        .b    (add_b_s),
        .cin  (add_cin_s),
        .sum  (add_sum_s),
        .cout (add_cout_s)
    );

    // Control FSM with capture registers and registered response outputs.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            last_grant_r <= 1'b1;
            opa_r        <= {DATA_W{1'b0}};
            opb_r        <= {DATA_W{1'b0}};
            op_r         <= 1'b0;
            id_r         <= 1'b0;
            tmp_sum_r    <= {DATA_W{1'b0}};
            tmp_cout_r   <= 1'b0;
            rsp_valid_r  <= 1'b0;
            rsp_id_r     <= 1'b0;
            rsp_sum_r    <= {DATA_W{1'b0}};
            rsp_cout_r   <= 1'b0;
            busy_r       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        opa_r        <= grant_s ? req1_a  : req0_a;
                        opb_r        <= grant_s ? req1_b  : req0_b;
                        op_r         <= grant_s ? req1_op : req0_op;
                        id_r         <= grant_s;
                        last_grant_r <= grant_s;
                        busy_r       <= 1'b1;
                        state_r      <= EXEC1;
                    end
                end
                EXEC1: begin
                    if (op_r == OP_SUB) begin
                        tmp_sum_r  <= add_sum_s;
                        tmp_cout_r <= add_cout_s;
                        state_r    <= EXEC2;
                    end else begin
                        rsp_sum_r   <= add_sum_s;
                        rsp_cout_r  <= add_cout_s;
                        rsp_id_r    <= id_r;
                        rsp_valid_r <= 1'b1;
                        state_r     <= DONE;
                    end
                end
                EXEC2: begin
                    rsp_sum_r   <= add_sum_s;
                    rsp_cout_r  <= tmp_cout_r | add_cout_s;
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                    state_r     <= DONE;
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        busy_r      <= 1'b0;
                        state_r     <= IDLE;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_sum   = rsp_sum_r;
    assign rsp_cout  = rsp_cout_r;
    assign busy      = busy_r;

endmodule

// File: doc/adder_arbiter.md
ADDER_ARBITER -- requirements
Module: adder_arbiter

Interface
REQ-001 Parameters: none; datapath width fixed at 64 bits.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req0_valid  input  1  requester 0 has an operation pending.
REQ-005 req0_ready  output  1  requester 0 operation accepted this cycle.
REQ-006 req0_a, req0_b  input  64 each  requester 0 operands.
REQ-007 req0_op  input  1  0 = add (a+b), 1 = subtract (a-b).
REQ-008 req1_valid / req1_ready / req1_a / req1_b / req1_op  as REQ-004..007, for requester 1.
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_ready  input  1  consumer takes result.
REQ-011 rsp_id  output  1  index of requester that issued the result.
REQ-012 rsp_sum  output  64  result.
REQ-013 rsp_cout  output  1  carry-out; for subtract, 1 = no borrow (a >= b unsigned).
REQ-014 busy  output  1  high in any state other than IDLE.

Function
REQ-015 FSM states SHALL be IDLE, EXEC1, EXEC2, DONE; one operation outstanding at a time.
REQ-016 In IDLE, arbitration: one valid -> grant it; both valid -> grant requester not granted last; after reset, requester 0 has priority.
REQ-017 reqN_ready SHALL be high only in IDLE, only for granted N, combinationally; handshake = valid & ready; operands, op, id captured on that edge; IDLE -> EXEC1.
REQ-018 EXEC1: single shared adder computes opA + opB (add) or opA + ~opB (subtract); sum and carry registered at end of cycle.
REQ-019 EXEC1 -> DONE for add; EXEC1 -> EXEC2 for subtract.
REQ-020 EXEC2: adder computes tmp + 1 (tmp = EXEC1 sum); rsp_sum = that sum; rsp_cout = EXEC1 carry OR EXEC2 carry.
REQ-021 Latency from handshake edge: add rsp_valid after 2 cycles, subtract after 3.
REQ-022 DONE: rsp_valid high; rsp_sum, rsp_cout, rsp_id stable until rsp_valid & rsp_ready; then -> IDLE.
REQ-023 No new request accepted in the rsp handshake cycle; next grant earliest in the following IDLE cycle (add throughput 1 per 3 cycles min).
REQ-024 Requester valid dropped while not granted: no effect; carry out of bit 63 never alters the 64-bit result (wrap-around modulo 2^64).
REQ-025 Round-robin pointer updates only on a request handshake, not on grant-without-handshake.

Reset
REQ-026 rst_n low at clock edge: state -> IDLE, last-grant pointer -> requester 1 (so requester 0 wins first tie), all registered outputs 0.
REQ-027 Reset values: req0_ready=0, req1_ready=0 during reset cycle, rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, busy=0.
REQ-028 Reset mid-operation (EXEC1/EXEC2/DONE) SHALL discard operation; no response produced afterward.

Structure
REQ-029 Shared package: width constant 64, op encoding (OP_ADD=0, OP_SUB=1), state enumeration.
REQ-030 Exactly one instance of add_64_bit SHALL be used for all arithmetic; operand muxing and inversion in this block.

Verification
REQ-031 req0 add a=5,b=7 alone -> req0_ready same cycle, rsp_valid 2 cycles later, rsp_sum=12, rsp_cout=0, rsp_id=0.
REQ-032 req1 sub a=10,b=3 -> rsp_valid 3 cycles after handshake, rsp_sum=7, rsp_cout=1, rsp_id=1; sub a=3,b=10 -> rsp_sum=0xFFFFFFFFFFFFFFF9, rsp_cout=0.
REQ-033 add a=0xFFFFFFFFFFFFFFFF, b=1 -> rsp_sum=0, rsp_cout=1; sub a=b=0 -> rsp_sum=0, rsp_cout=1.
REQ-034 Both valid continuously after reset, 4 ops -> grants 0,1,0,1; rsp_id matches grant order.
REQ-035 rsp_ready held low 5 cycles in DONE -> outputs stable, no req_ready asserted, busy=1; release -> IDLE next cycle.
REQ-036 rst_n low during EXEC2 of a subtract -> next cycle rsp_valid=0, busy=0, no later response for that operation.
